// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EXM stage: one quotient bit per cycle,
// signed handled by magnitude division plus sign fix-up, flushable at any point.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_unsigned,
    input  logic             use_mod,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] result_reg;
    logic             uns_reg;
    logic             mod_reg;
    logic             q_neg;
    logic             r_neg;
    logic             res_valid_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_fixed;
    logic [WIDTH-1:0] quo_fixed;

    always_comb begin
        a_abs     = (!uns_reg && a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
        b_abs     = (!uns_reg && b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;
        // Partial remainder is always below the divisor, so WIDTH+1 bits never overflow.
        shifted   = {rem_reg, quo_reg[WIDTH-1]};
        diff      = shifted - {1'b0, b_reg};
        rem_fixed = r_neg ? (~rem_reg + 1'b1) : rem_reg;
        quo_fixed = q_neg ? (~quo_reg + 1'b1) : quo_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            result_reg    <= '0;
            uns_reg       <= 1'b0;
            mod_reg       <= 1'b0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            res_valid_reg <= 1'b0;
            cnt           <= '0;
        end else if (flush) begin
            state         <= IDLE;
            res_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg   <= src1;
                        b_reg   <= src2;
                        uns_reg <= is_unsigned;
                        mod_reg <= use_mod;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    if (b_reg == '0) begin
                        // Divide-by-zero still passes through FIX so its result lands one cycle later.
                        quo_reg <= '1;
                        rem_reg <= a_reg;
                        q_neg   <= 1'b0;
                        r_neg   <= 1'b0;
                        state   <= FIX;
                    end else begin
                        quo_reg <= a_abs;
                        b_reg   <= b_abs;
                        rem_reg <= '0;
                        q_neg   <= !uns_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                        r_neg   <= !uns_reg && a_reg[WIDTH-1];
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!diff[WIDTH]) begin
                        rem_reg <= diff[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[WIDTH-1:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_reg    <= mod_reg ? rem_fixed : quo_fixed;
                    res_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);
    assign res_valid = res_valid_reg;
    assign result    = result_reg;

endmodule
